// File: rtl/controller_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : controller_fsm_if
// Description : Control bus between the multi-cycle controller and its
//               datapath. The datapath supplies the IR1 opcode nibble; the
//               controller drives every select, enable and ALU control.
// Revision    : 1.0 - initial release
// ============================================================================
interface controller_fsm_if;
    logic [3:0] opcode;      // IR1[7:4]
    logic       pcSelect;    // 0: ALU-out, 1: IR2
    logic       pcEnable;
    logic       adrSelect;   // 0: PC, 1: IR2
    logic       ir1En;
    logic       ir2En;
    logic       regSelect;   // 0: IR1[3:0], 1: IR2[7:4]
    logic       wd3Select;   // 0: memRD, 1: ALU-out
    logic       regWrite;
    logic       op1Sel;      // 0: PC, 1: RD1
    logic       op2Sel;      // 0: RD2, 1: constant 1
    logic       aluOutEn;
    logic [2:0] aluControl;
    logic       memWrite;
    logic       halted;

    // Controller side
    modport master (
        input  opcode,
        output pcSelect, pcEnable, adrSelect, ir1En, ir2En,
        output regSelect, wd3Select, regWrite, op1Sel, op2Sel,
        output aluOutEn, aluControl, memWrite, halted
    );

    // Datapath side
    modport slave (
        output opcode,
        input  pcSelect, pcEnable, adrSelect, ir1En, ir2En,
        input  regSelect, wd3Select, regWrite, op1Sel, op2Sel,
        input  aluOutEn, aluControl, memWrite, halted
    );
endinterface
`default_nettype wire

// File: rtl/controller_fsm.sv
`default_nettype none
// ============================================================================
// Module      : controller_fsm
// Description : Moore controller for a small 8-bit multi-cycle CPU.
//               FETCH1 -> FETCH2 -> EXEC per instruction, HALT is terminal
//               until reset. Outputs are registered: the control word for the
//               state being entered is computed on the same edge.
//               Optional macro CONTROLLER_LOAD_WAIT_EN adds an LDWAIT state
//               so LD writes back one cycle later (synchronous-read memory).
// Revision    : 1.0 - initial release
// ============================================================================
module controller_fsm (
    input  wire logic       clk,
    input  wire logic       reset,
    controller_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH1 = 3'd0,
        S_FETCH2 = 3'd1,
        S_EXEC   = 3'd2,
`ifdef CONTROLLER_LOAD_WAIT_EN
        S_LDWAIT = 3'd4,
`endif
        S_HALT   = 3'd3
    } state_t;

    typedef struct packed {
        logic       pcSelect;
        logic       pcEnable;
        logic       adrSelect;
        logic       ir1En;
        logic       ir2En;
        logic       regSelect;
        logic       wd3Select;
        logic       regWrite;
        logic       op1Sel;
        logic       op2Sel;
        logic       aluOutEn;
        logic [2:0] aluControl;
        logic       memWrite;
        logic       halted;
    } ctrl_t;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [3:0] c_OP_LD   = 4'h8;
    localparam logic [3:0] c_OP_ST   = 4'h9;
    localparam logic [3:0] c_OP_JMP  = 4'hA;
    localparam logic [3:0] c_OP_INC  = 4'hB;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    state_t r_state;
    state_t w_next_state;
    ctrl_t  r_ctrl;

    // Control word for a given state; opcode matters only in EXEC.
    // Anything not set explicitly stays 0.
    function automatic ctrl_t f_decode(input state_t st, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH1: begin
                c.ir1En      = 1'b1;
                c.op2Sel     = 1'b1;
                c.aluControl = c_ALU_ADD;
                c.pcEnable   = 1'b1;
            end
            S_FETCH2: begin
                c.ir2En      = 1'b1;
                c.op2Sel     = 1'b1;
                c.aluControl = c_ALU_ADD;
                c.pcEnable   = 1'b1;
            end
            S_EXEC: begin
                if (!op[3]) begin
                    // rd = rs op rt
                    c.regSelect  = 1'b1;
                    c.op1Sel     = 1'b1;
                    c.aluControl = op[2:0];
                    c.wd3Select  = 1'b1;
                    c.regWrite   = 1'b1;
                    c.aluOutEn   = 1'b1;
                end else begin
                    case (op)
                        c_OP_LD: begin
                            c.adrSelect = 1'b1;
`ifdef CONTROLLER_LOAD_WAIT_EN
                            c.regWrite  = 1'b0;
`else
                            c.regWrite  = 1'b1;
`endif
                        end
                        c_OP_ST: begin
                            c.adrSelect = 1'b1;
                            c.memWrite  = 1'b1;
                        end
                        c_OP_JMP: begin
                            c.pcSelect = 1'b1;
                            c.pcEnable = 1'b1;
                        end
                        c_OP_INC: begin
                            c.op1Sel     = 1'b1;
                            c.op2Sel     = 1'b1;
                            c.aluControl = c_ALU_ADD;
                            c.wd3Select  = 1'b1;
                            c.regWrite   = 1'b1;
                        end
                        default: ;  // NOP and HALT assert nothing
                    endcase
                end
            end
`ifdef CONTROLLER_LOAD_WAIT_EN
            S_LDWAIT: begin
                c.adrSelect = 1'b1;
                c.regWrite  = 1'b1;
            end
`endif
            S_HALT: begin
                c.halted = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state selection.
    always_comb begin
        w_next_state = S_FETCH1;
        case (r_state)
            S_FETCH1: w_next_state = S_FETCH2;
            S_FETCH2: w_next_state = S_EXEC;
            S_EXEC: begin
                if (bus.opcode == c_OP_HALT) begin
                    w_next_state = S_HALT;
`ifdef CONTROLLER_LOAD_WAIT_EN
                end else if (bus.opcode == c_OP_LD) begin
                    w_next_state = S_LDWAIT;
`endif
                end else begin
                    w_next_state = S_FETCH1;
                end
            end
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_FETCH1;
        endcase
    end

    // State and registered control word; reset shows FETCH1 controls at once.
    // IR1 is already loaded when EXEC is entered, so opcode is valid here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH1;
            r_ctrl  <= f_decode(S_FETCH1, 4'h0);
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= f_decode(w_next_state, bus.opcode);
        end
    end

    assign bus.pcSelect   = r_ctrl.pcSelect;
    assign bus.pcEnable   = r_ctrl.pcEnable;
    assign bus.adrSelect  = r_ctrl.adrSelect;
    assign bus.ir1En      = r_ctrl.ir1En;
    assign bus.ir2En      = r_ctrl.ir2En;
    assign bus.regSelect  = r_ctrl.regSelect;
    assign bus.wd3Select  = r_ctrl.wd3Select;
    assign bus.regWrite   = r_ctrl.regWrite;
    assign bus.op1Sel     = r_ctrl.op1Sel;
    assign bus.op2Sel     = r_ctrl.op2Sel;
    assign bus.aluOutEn   = r_ctrl.aluOutEn;
    assign bus.aluControl = r_ctrl.aluControl;
    assign bus.memWrite   = r_ctrl.memWrite;
    assign bus.halted     = r_ctrl.halted;

endmodule
`default_nettype wire

// File: tb/tb_controller_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller_fsm
// Description : Directed bench for controller_fsm. Each control word is
//               packed as {pcSelect,pcEnable,adrSelect,ir1En,ir2En,
//               regSelect,wd3Select,regWrite,op1Sel,op2Sel,aluOutEn,
//               aluControl[2:0],memWrite,halted} and compared against
//               hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controller_fsm;

    localparam logic [15:0] c_V_FETCH1 = 16'h5040;
    localparam logic [15:0] c_V_FETCH2 = 16'h4840;
    localparam logic [15:0] c_V_HALT   = 16'h0001;
    localparam logic [15:0] c_V_NONE   = 16'h0000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_stores;

    controller_fsm_if u_if ();

    controller_fsm u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stores actually committed on a rising edge.
    always @(posedge clk) begin
        if (u_if.memWrite && !reset) n_stores <= n_stores + 1;
    end

    function automatic logic [15:0] f_vec();
        return {u_if.pcSelect, u_if.pcEnable, u_if.adrSelect, u_if.ir1En,
                u_if.ir2En, u_if.regSelect, u_if.wd3Select, u_if.regWrite,
                u_if.op1Sel, u_if.op2Sel, u_if.aluOutEn, u_if.aluControl,
                u_if.memWrite, u_if.halted};
    endfunction

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a falling edge with the DUT in FETCH1; returns at the
    // falling edge of the cycle after EXEC (or after LDWAIT).
    task automatic run_instr(input string tag, input logic [3:0] op,
                             input logic [15:0] exp_exec, input bit ldwait);
        u_if.opcode = op;
        check({tag, "_fetch1"}, f_vec(), c_V_FETCH1);
        @(negedge clk);
        check({tag, "_fetch2"}, f_vec(), c_V_FETCH2);
        @(negedge clk);
        check({tag, "_exec"}, f_vec(), exp_exec);
        @(negedge clk);
        if (ldwait) begin
            check({tag, "_ldwait"}, f_vec(), 16'h2100);
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        n_stores    = 0;
        reset       = 1'b1;
        u_if.opcode = 4'h0;

        // Reset: FETCH1 controls even while the clock runs
        #3;
        check("reset_async", f_vec(), c_V_FETCH1);
        @(negedge clk);
        @(negedge clk);
        check("reset_held", f_vec(), c_V_FETCH1);
        reset = 1'b0;

        run_instr("alu3", 4'h3, 16'h07AC, 1'b0);
        run_instr("alu0", 4'h0, 16'h07A0, 1'b0);
        run_instr("alu7", 4'h7, 16'h07BC, 1'b0);
        run_instr("alu5", 4'h5, 16'h07B4, 1'b0);
`ifdef CONTROLLER_LOAD_WAIT_EN
        run_instr("ld",   4'h8, 16'h2000, 1'b1);
`else
        run_instr("ld",   4'h8, 16'h2100, 1'b0);
`endif
        run_instr("st",   4'h9, 16'h2002, 1'b0);
        check("st_single", f_vec(), c_V_FETCH1);
        run_instr("jmp",  4'hA, 16'hC000, 1'b0);
        run_instr("inc",  4'hB, 16'h03C0, 1'b0);
        run_instr("nopC", 4'hC, c_V_NONE, 1'b0);
        run_instr("nopE", 4'hE, c_V_NONE, 1'b0);

        // Reset in the middle of a store's EXEC cycle
        u_if.opcode = 4'h9;
        check("rst_st_fetch1", f_vec(), c_V_FETCH1);
        @(negedge clk);
        @(negedge clk);
        check("rst_st_exec", f_vec(), 16'h2002);
        #2 reset = 1'b1;
        #1 check("rst_st_abort", f_vec(), c_V_FETCH1);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_st_release", f_vec(), c_V_FETCH1);
        run_instr("post_rst", 4'h3, 16'h07AC, 1'b0);

        // HALT is sticky for ten cycles, then a reset pulse restarts fetch
        run_instr("halt", 4'hF, c_V_NONE, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("halted_%0d", i), f_vec(), c_V_HALT);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1 check("halt_rst", f_vec(), c_V_FETCH1);
        @(negedge clk);
        reset = 1'b0;
        run_instr("after_halt", 4'hB, 16'h03C0, 1'b0);

        check("store_count", 16'(n_stores), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
